btn_event_arbiter: RTL and testbench
====================================

# btn_event_arbiter

Converts the debounced button levels of the MITM board into discrete press events (short/long) and serialises them onto a single valid/ready event port for the mode-control logic. Each button has its own press classifier; a round-robin arbiter shares the one output port between all buttons. Sits directly downstream of the per-button debouncers, in the `sys_clk` domain.

## Interface
- `NUM_BTNS`, 4: number of button channels, 2..8.
- `SYS_CLK_HZ`, 12_000_000: system clock frequency.
- `LONG_PRESS_MS`, 1000: hold time that classifies a press as long; LONG_CYCLES = SYS_CLK_HZ/1000*LONG_PRESS_MS.
- `sys_clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `btn_in`  in  NUM_BTNS  debounced button levels, 1 = pressed.
- `evt_valid`  out  1  event available.
- `evt_ready`  in  1  consumer accepts event when high with evt_valid.
- `evt_id`  out  $clog2(NUM_BTNS)  channel index of the event.
- `evt_long`  out  1  1 = long press, 0 = short press.
- `evt_overrun`  out  1  at least one earlier event from this channel was overwritten before being sent.

## Operation
- Per channel: registered copy `btn_q`; press edge = `btn_in & ~btn_q`, release edge = `~btn_in & btn_q`.
- Channel FSM: IDLE -> PRESSED on press edge (counter cleared to 0). PRESSED: counter increments, saturating at LONG_CYCLES. PRESSED -> IDLE on release with counter < LONG_CYCLES: raise short event. PRESSED -> HELD when counter reaches LONG_CYCLES: raise long event once. HELD -> IDLE on release: no event.
- Counter width $clog2(LONG_CYCLES+1); unsigned, never wraps.
- Each channel holds one pending slot (valid + type) and a sticky overrun bit.
- A new event while the slot is still pending and not granted this cycle: slot overwritten with the newest type; overrun bit set.
- A new event in the same cycle the slot is granted: the granted (old) event goes out; the new event fills the slot; overrun is not set.
- Arbiter: output register loads when empty or accepted this cycle (`~evt_valid | evt_ready`). Search starts at `rr_ptr`, picks the first pending channel, and clears its pending and overrun bits. The overrun bit is copied to `evt_overrun`. `rr_ptr` becomes the granted index + 1, mod NUM_BTNS.
- While `evt_valid & ~evt_ready`: `evt_id`, `evt_long` and `evt_overrun` are held stable.

## Timing
- Reset values: `evt_valid`=0, `evt_id`=0, `evt_long`=0, `evt_overrun`=0; all FSMs IDLE; `btn_q`=0; pending/overrun=0; `rr_ptr`=0.
- Latency: edge on `btn_in` sampled at clock edge k sets pending at k; `evt_valid` is high after edge k+1 (2 cycles), provided the output register is free.
- Long event: pending set on the cycle the counter reaches LONG_CYCLES, i.e. LONG_CYCLES cycles after the press edge was sampled.
- Throughput: one event per cycle with `evt_ready` tied high.
- Button held through reset release: a press edge is seen on the first clock after reset.
- Reset asserted mid-press or with an event pending: the event is discarded.

## Configuration
- `BTN_EVT_LONG_PRESS_EN` defined: long-press classification as above.
- Not defined:
  - No counters and no HELD state.
  - Every release produces a short event.
  - `evt_long` is constant 0.
  - `LONG_PRESS_MS` is ignored.

## Structure
- Shared package: channel FSM state enum (IDLE/PRESSED/HELD) and the event type encoding (SHORT=0, LONG=1).
- Sub-module `btn_press_classifier`, one instance per channel: edge detect, FSM, counter, event strobe + type. The top holds the pending slots, overrun bits, round-robin arbiter and output register.

## Test plan
Bench uses NUM_BTNS=4, SYS_CLK_HZ=12_000_000, LONG_PRESS_MS=1 (LONG_CYCLES=12000).
- Reset check: pulse `rst` with `btn_in`=0 -> all outputs 0; no `evt_valid` for 20000 cycles.
- Short press: btn 2 high for 100 cycles, `evt_ready`=1 -> one `evt_valid` pulse 2 cycles after release, `evt_id`=2, `evt_long`=0, `evt_overrun`=0.
- Long press: btn 1 held 15000 cycles -> `evt_id`=1, `evt_long`=1 valid at 12000+2 cycles after the press; nothing on release.
- Fairness: `evt_ready`=0; short presses on btns 0, 1, 3 complete; then `evt_ready`=1 -> ids 0, 1, 3 in order, each exactly once.
- Overrun: `evt_ready`=0 with btn 0's event in the output register; btn 3 pressed twice, then `evt_ready`=1 -> btn 0's event, then a single btn 3 event with `evt_overrun`=1; the next btn 3 event has `evt_overrun`=0.
- Macro off: btn 1 held 15000 cycles -> one event on release, `evt_long`=0.

Source files
------------

// File: rtl/btn_event_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_arbiter_pkg
// Shared types for the button event path: the per-channel press classifier
// FSM state encoding and the press event type encoding.
// -----------------------------------------------------------------------------
package btn_event_arbiter_pkg;

    // Per-channel press classifier states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    // Event type carried on evt_long
    typedef enum logic {
        EVT_SHORT = 1'b0,
        EVT_LONG  = 1'b1
    } evt_type_e;

    // Round-robin successor of a channel index, wrapping at num_btns
    function automatic int unsigned rr_succ(input int unsigned idx, input int unsigned num_btns);
        int unsigned nxt;
        if (idx + 32'd1 >= num_btns) begin
            nxt = 32'd0;
        end else begin
            nxt = idx + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_event_arbiter_classifier.sv
// -----------------------------------------------------------------------------
// btn_press_classifier
// Turns one debounced button level into a single-cycle event strobe plus
// event type (short/long). The strobe is combinational from the current state
// and the sampled edge, so the parent's pending slot is written on the same
// clock edge that samples the release (or the long-press threshold).
//
// Optional feature macro: BTN_EVT_LONG_PRESS_EN
//   defined     : hold counter + HELD state, long event raised once at
//                 LONG_CYCLES, no event on release from HELD.
//   not defined : no counter, every release gives a short event.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   btn_in     in   debounced button level, 1 = pressed
//   evt_stb    out  one-cycle event strobe
//   evt_type   out  event type (0 = short, 1 = long), valid with evt_stb
// -----------------------------------------------------------------------------
module btn_press_classifier
    import btn_event_arbiter_pkg::*;
#(
    parameter int LONG_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic evt_stb,
    output logic evt_type
);

    logic       btn_q_r;
    logic       press_s;
    logic       release_s;
    btn_state_e state_r;
    btn_state_e state_s;

    assign press_s   = btn_in & ~btn_q_r;
    assign release_s = ~btn_in & btn_q_r;

    // Registered copy of the button level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q_r <= 1'b0;
        end else begin
            btn_q_r <= btn_in;
        end
    end

`ifdef BTN_EVT_LONG_PRESS_EN

    localparam int              CW       = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(LONG_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(LONG_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    // State and hold-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and counter logic; counter saturates at LONG_CYCLES
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (press_s) begin
                    state_s = ST_PRESSED;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (release_s) begin
                    state_s = ST_IDLE;
                end else begin
                    if (cnt_r < CNT_MAX) begin
                        cnt_s = cnt_r + CW'(1);
                    end else begin
                        cnt_s = CNT_MAX;
                    end
                    // Counter reaches LONG_CYCLES on this edge
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_HELD;
                    end else begin
                        state_s = ST_PRESSED;
                    end
                end
            end
            ST_HELD: begin
                if (release_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HELD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Event strobe: release wins over reaching the threshold in the same cycle
    always_comb begin
        evt_stb  = 1'b0;
        evt_type = EVT_SHORT;
        case (state_r)
            ST_PRESSED: begin
                if (release_s) begin
                    evt_stb  = 1'b1;
                    evt_type = EVT_SHORT;
                end else if (cnt_r == CNT_LAST) begin
                    evt_stb  = 1'b1;
                    evt_type = EVT_LONG;
                end else begin
                    evt_stb  = 1'b0;
                end
            end
            default: begin
                evt_stb  = 1'b0;
                evt_type = EVT_SHORT;
            end
        endcase
    end

`else

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: press/release toggling only
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (press_s) begin
                    state_s = ST_PRESSED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (release_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PRESSED;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Event strobe: every release is a short press
    always_comb begin
        evt_stb  = 1'b0;
        evt_type = EVT_SHORT;
        case (state_r)
            ST_PRESSED: begin
                if (release_s) begin
                    evt_stb = 1'b1;
                end else begin
                    evt_stb = 1'b0;
                end
            end
            default: begin
                evt_stb = 1'b0;
            end
        endcase
    end

`endif

endmodule

// File: rtl/btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// btn_event_arbiter
// Converts debounced button levels into short/long press events and
// serialises them onto one valid/ready port. One btn_press_classifier per
// channel; this level holds a one-deep pending slot and sticky overrun bit per
// channel, a round-robin arbiter and the registered output stage.
//
// Optional feature macro: BTN_EVT_LONG_PRESS_EN (long-press classification).
// Without it evt_long is always 0 and LONG_PRESS_MS has no effect.
//
// Ports:
//   sys_clk      in   system clock
//   rst          in   asynchronous active-high reset
//   btn_in       in   [NUM_BTNS] debounced levels, 1 = pressed
//   evt_valid    out  event available
//   evt_ready    in   consumer accepts when high with evt_valid
//   evt_id       out  [$clog2(NUM_BTNS)] channel of the event
//   evt_long     out  1 = long press, 0 = short press
//   evt_overrun  out  an earlier event of this channel was overwritten
// -----------------------------------------------------------------------------
module btn_event_arbiter
    import btn_event_arbiter_pkg::*;
#(
    parameter int NUM_BTNS      = 4,
    parameter int SYS_CLK_HZ    = 12_000_000,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic [NUM_BTNS-1:0]         btn_in,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(NUM_BTNS)-1:0] evt_id,
    output logic                        evt_long,
    output logic                        evt_overrun
);

    localparam int IDW         = $clog2(NUM_BTNS);
    localparam int LONG_CYCLES = SYS_CLK_HZ / 1000 * LONG_PRESS_MS;

    logic [NUM_BTNS-1:0] stb_s;
    logic [NUM_BTNS-1:0] type_s;
    logic [NUM_BTNS-1:0] pending_r;
    logic [NUM_BTNS-1:0] long_r;
    logic [NUM_BTNS-1:0] ovr_r;
    logic [NUM_BTNS-1:0] grant_s;
    logic [IDW-1:0]      rr_ptr_r;
    logic [IDW-1:0]      gnt_idx_s;
    logic                found_s;
    logic                load_s;
    logic                evt_valid_r;
    logic [IDW-1:0]      evt_id_r;
    logic                evt_long_r;
    logic                evt_overrun_r;

    genvar g;
    generate
        for (g = 0; g < NUM_BTNS; g++) begin : g_chan
            btn_press_classifier #(
                .LONG_CYCLES (LONG_CYCLES)
            ) u_classifier (
                .clk      (sys_clk),
                .rst      (rst),
                .btn_in   (btn_in[g]),
                .evt_stb  (stb_s[g]),
                .evt_type (type_s[g])
            );
        end
    endgenerate

    // Output stage is free when empty or being accepted this cycle
    assign load_s = ~evt_valid_r | evt_ready;

    // Round-robin search starting at rr_ptr for the first pending channel
    always_comb begin
        int unsigned   idx_v;
        logic [IDW-1:0] sel_v;
        found_s   = 1'b0;
        gnt_idx_s = '0;
        grant_s   = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            idx_v = (32'(rr_ptr_r) + 32'(i)) % 32'(NUM_BTNS);
            sel_v = IDW'(idx_v);
            if (!found_s && pending_r[sel_v]) begin
                found_s   = 1'b1;
                gnt_idx_s = sel_v;
            end else begin
                found_s   = found_s;
            end
        end
        if (load_s && found_s) begin
            grant_s[gnt_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Pending slots and sticky overrun bits; a new event beats a grant clear
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pending_r <= '0;
            long_r    <= '0;
            ovr_r     <= '0;
        end else begin
            for (int c = 0; c < NUM_BTNS; c++) begin
                if (stb_s[c]) begin
                    pending_r[c] <= 1'b1;
                    long_r[c]    <= type_s[c];
                    if (grant_s[c]) begin
                        // Old event leaves with its own overrun flag
                        ovr_r[c] <= 1'b0;
                    end else begin
                        ovr_r[c] <= ovr_r[c] | pending_r[c];
                    end
                end else if (grant_s[c]) begin
                    pending_r[c] <= 1'b0;
                    ovr_r[c]     <= 1'b0;
                end else begin
                    pending_r[c] <= pending_r[c];
                end
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            evt_valid_r   <= 1'b0;
            evt_id_r      <= '0;
            evt_long_r    <= 1'b0;
            evt_overrun_r <= 1'b0;
            rr_ptr_r      <= '0;
        end else if (load_s) begin
            evt_valid_r <= found_s;
            if (found_s) begin
                evt_id_r      <= gnt_idx_s;
                evt_long_r    <= long_r[gnt_idx_s];
                evt_overrun_r <= ovr_r[gnt_idx_s];
                rr_ptr_r      <= IDW'(rr_succ(32'(gnt_idx_s), 32'(NUM_BTNS)));
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end else begin
            evt_valid_r <= evt_valid_r;
        end
    end

    assign evt_valid   = evt_valid_r;
    assign evt_id      = evt_id_r;
    assign evt_long    = evt_long_r;
    assign evt_overrun = evt_overrun_r;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_btn_event_arbiter
// Directed bench with a scoreboard: stimulus pushes expected events, a
// monitor pops and compares on every accepted handshake and checks that the
// output is held stable while stalled.
// -----------------------------------------------------------------------------
module tb_btn_event_arbiter;

    localparam int NB = 4;
    localparam int LC = 12000;

    logic          sys_clk = 1'b0;
    logic          rst     = 1'b1;
    logic [NB-1:0] btn_in  = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [1:0]    evt_id;
    logic          evt_long;
    logic          evt_overrun;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] id;
        logic       lng;
        logic       ovr;
    } evt_t;

    evt_t exp_q[$];
    logic prev_stall = 1'b0;
    evt_t prev_evt;

    btn_event_arbiter #(
        .NUM_BTNS      (NB),
        .SYS_CLK_HZ    (12_000_000),
        .LONG_PRESS_MS (1)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .evt_long    (evt_long),
        .evt_overrun (evt_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n clocks, landing just after the rising edge
    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic lng, input logic ovr);
        evt_t e;
        e.id  = id;
        e.lng = lng;
        e.ovr = ovr;
        exp_q.push_back(e);
    endtask

    task automatic tap(input int b, input int hold);
        btn_in[b] = 1'b1;
        step(hold);
        btn_in[b] = 1'b0;
        step(3);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: compare each accepted event and stall stability
    always @(negedge sys_clk) begin
        evt_t e;
        if (!rst) begin
            if (prev_stall) begin
                check("hold_stable", {evt_valid, evt_id, evt_long, evt_overrun}, {1'b1, prev_evt});
            end
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {evt_id, evt_long, evt_overrun}, 32'hFF);
                end else begin
                    e = exp_q.pop_front();
                    check("event", {evt_id, evt_long, evt_overrun}, e);
                end
            end
            prev_stall = evt_valid & ~evt_ready;
            prev_evt   = {evt_id, evt_long, evt_overrun};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int vcnt;

        // Reset state
        step(3);
        check("reset_outputs", {evt_valid, evt_id, evt_long, evt_overrun}, 5'd0);
        rst       = 1'b0;
        evt_ready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 20000; i++) begin
            step(1);
            if (evt_valid) vcnt++;
        end
        check("idle_no_valid", vcnt, 0);

        // Short press on btn 2 with exact latency
        push(2'd2, 1'b0, 1'b0);
        btn_in[2] = 1'b1;
        step(100);
        btn_in[2] = 1'b0;
        step(1);
        check("short_lat_early", evt_valid, 1'b0);
        step(1);
        check("short_lat_valid", {evt_valid, evt_id, evt_long}, {1'b1, 2'd2, 1'b0});
        step(1);
        check("short_single", evt_valid, 1'b0);
        wait_empty("short_drain");

        // Long hold on btn 1
        btn_in[1] = 1'b1;
`ifdef BTN_EVT_LONG_PRESS_EN
        push(2'd1, 1'b1, 1'b0);
        step(LC + 1);
        check("long_lat_early", evt_valid, 1'b0);
        step(1);
        check("long_lat_valid", {evt_valid, evt_id, evt_long}, {1'b1, 2'd1, 1'b1});
        step(15000 - LC - 2);
        btn_in[1] = 1'b0;
        step(5);
        check("long_no_release_evt", exp_q.size(), 0);
`else
        step(LC + 2);
        check("nolong_no_evt", evt_valid, 1'b0);
        step(15000 - LC - 2);
        push(2'd1, 1'b0, 1'b0);
        btn_in[1] = 1'b0;
        step(1);
        check("nolong_lat_early", evt_valid, 1'b0);
        step(1);
        check("nolong_release_evt", {evt_valid, evt_id, evt_long}, {1'b1, 2'd1, 1'b0});
        wait_empty("nolong_drain");
`endif

        // Fairness: three events queued while stalled
        evt_ready = 1'b0;
        push(2'd0, 1'b0, 1'b0);
        tap(0, 5);
        push(2'd1, 1'b0, 1'b0);
        tap(1, 5);
        push(2'd3, 1'b0, 1'b0);
        tap(3, 5);
        check("fair_stalled_head", {evt_valid, evt_id}, {1'b1, 2'd0});
        evt_ready = 1'b1;
        wait_empty("fair_drain");
        step(3);
        check("fair_idle", evt_valid, 1'b0);

        // Overrun: btn 3 pressed twice behind a stalled btn 0 event
        evt_ready = 1'b0;
        push(2'd0, 1'b0, 1'b0);
        tap(0, 5);
        tap(3, 5);
        tap(3, 5);
        push(2'd3, 1'b0, 1'b1);
        evt_ready = 1'b1;
        wait_empty("ovr_drain");
        push(2'd3, 1'b0, 1'b0);
        tap(3, 5);
        wait_empty("ovr_clear_drain");

        // Reset mid-press discards the press
        btn_in[2] = 1'b1;
        step(50);
        rst = 1'b1;
        step(2);
        btn_in[2] = 1'b0;
        check("rst_mid_outputs", {evt_valid, evt_id, evt_long, evt_overrun}, 5'd0);
        rst = 1'b0;
        step(20);
        check("rst_mid_discard", evt_valid, 1'b0);

        // Button held through reset release gives a press edge
        btn_in[1] = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(10);
        push(2'd1, 1'b0, 1'b0);
        btn_in[1] = 1'b0;
        wait_empty("held_thru_rst");

        step(10);
        check("final_queue", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
